// File: rtl/spart_tx_scheduler.sv
// Round-robin scheduler sharing one SPART transmitter among NREQ requesters, with watchdog/retry.
// Define SPART_ACK_EN to also wait for the peer's response frame (WAIT_RSP) and return it on rsp_data.
module spart_tx_scheduler #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DW          = 24,
  parameter int unsigned TIMEOUT_CYC = 2000000,
  parameter int unsigned RETRY_MAX   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    done,
  output logic [NREQ-1:0]    err,
  output logic [DW-1:0]      rsp_data,
  output logic               busy,
  output logic               start_transmission,
  output logic [DW-1:0]      tdata,
  input  logic               tx_done,
  input  logic               rx_done,
  input  logic [DW-1:0]      rdata
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_RSP,
    S_FIN
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   timer;
  logic [RW-1:0]   retries;
  logic            grant_any;
  logic [IW-1:0]   grant_idx;
  int unsigned     scan;
  logic [NREQ-1:0] idx_onehot;
  logic            timeout;
  logic            retry_left;
  logic [TW-1:0]   timer_next;

  // First requester at or after ptr, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = 32'(ptr) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      if (!grant_any && req[scan]) begin
        grant_any = 1'b1;
        grant_idx = IW'(scan);
      end
    end
  end

  always_comb begin
    idx_onehot = '0;
    idx_onehot[idx] = 1'b1;
  end

  assign timeout    = (timer == TW'(TIMEOUT_CYC - 1));
  assign retry_left = (retries < RW'(RETRY_MAX));
  assign timer_next = (timer == '1) ? timer : timer + 1'b1;

`ifndef SPART_ACK_EN
  logic unused_rx;
  assign unused_rx = ^{rx_done, rdata};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      ptr                <= '0;
      idx                <= '0;
      timer              <= '0;
      retries            <= '0;
      done               <= '0;
      err                <= '0;
      rsp_data           <= '0;
      busy               <= 1'b0;
      start_transmission <= 1'b0;
      tdata              <= '0;
    end else begin
      start_transmission <= 1'b0;
      done               <= '0;
      err                <= '0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            idx   <= grant_idx;
            tdata <= req_data[32'(grant_idx) * DW +: DW];
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          start_transmission <= 1'b1;
          timer              <= '0;
          state              <= S_SEND;
        end
        S_SEND: begin
          // tx_done takes priority over a timeout landing in the same cycle.
          if (tx_done) begin
`ifdef SPART_ACK_EN
            timer <= '0;
            state <= S_WAIT_RSP;
`else
            done  <= idx_onehot;
            state <= S_FIN;
`endif
          end else if (timeout) begin
            if (retry_left) begin
              retries <= retries + 1'b1;
              state   <= S_LOAD;
            end else begin
              err   <= idx_onehot;
              state <= S_FIN;
            end
          end else begin
            timer <= timer_next;
          end
        end
`ifdef SPART_ACK_EN
        S_WAIT_RSP: begin
          if (rx_done) begin
            rsp_data <= rdata;
            done     <= idx_onehot;
            state    <= S_FIN;
          end else if (timeout) begin
            if (retry_left) begin
              retries <= retries + 1'b1;
              state   <= S_LOAD;
            end else begin
              err   <= idx_onehot;
              state <= S_FIN;
            end
          end else begin
            timer <= timer_next;
          end
        end
`endif
        S_FIN: begin
          ptr     <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          retries <= '0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spart_tx_scheduler.sv
// Directed, table-driven bench for spart_tx_scheduler (NREQ=4, TIMEOUT_CYC=100, RETRY_MAX=2).
// Builds with or without SPART_ACK_EN; with it, each frame is answered by a response frame.
module tb_spart_tx_scheduler;
  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 24;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [DW-1:0]      rsp_data;
  logic               busy;
  logic               start_transmission;
  logic [DW-1:0]      tdata;
  logic               tx_done;
  logic               rx_done;
  logic [DW-1:0]      rdata;

  int checks = 0;
  int errors = 0;

  spart_tx_scheduler #(
    .NREQ(NREQ),
    .DW(DW),
    .TIMEOUT_CYC(100),
    .RETRY_MAX(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .done(done),
    .err(err),
    .rsp_data(rsp_data),
    .busy(busy),
    .start_transmission(start_transmission),
    .tdata(tdata),
    .tx_done(tx_done),
    .rx_done(rx_done),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    int         idx;       // expected grant
    int         ok_start;  // first start (1-based) that gets a tx_done
    int         delay;     // cycles after that start to pulse tx_done; -1 never
    bit         ok;        // 1: done expected, 0: err expected
    int         starts;    // expected number of start pulses
  } rec_t;

  rec_t recs[10];

  function automatic logic [DW-1:0] exp_frame(input int i);
    case (i)
      0:       return 24'hBEEFDE;
      1:       return 24'h123456;
      2:       return 24'hABCDEF;
      default: return 24'h0F1E2D;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rec(input rec_t r);
    int         starts;
    int         since;
    int         ack_wait;
    bit         fin;
    logic [3:0] got_done;
    logic [3:0] got_err;
    logic [3:0] onehot;
    logic [DW-1:0] got_rsp;
    logic [DW-1:0] exp_rsp;
    exp_rsp = '0;
`ifdef SPART_ACK_EN
    exp_rsp = exp_frame(r.idx) ^ 24'h5A5A5A;
`endif
    onehot   = 4'b0001 << r.idx;
    req      = r.req;
    starts   = 0;
    since    = 0;
    ack_wait = 0;
    fin      = 1'b0;
    got_done = '0;
    got_err  = '0;
    got_rsp  = '0;
    for (int c = 0; c < 700 && !fin; c++) begin
      step();
      tx_done = 1'b0;
      rx_done = 1'b0;
      if (start_transmission) begin
        starts++;
        since = 0;
        chk("rec_tdata", tdata, exp_frame(r.idx));
        chk("rec_busy_in_flight", busy, 1'b1);
      end else begin
        since++;
      end
      if (done != 0 || err != 0) begin
        fin      = 1'b1;
        got_done = done;
        got_err  = err;
        got_rsp  = rsp_data;
      end else if (starts >= r.ok_start && r.delay >= 0 && since == r.delay) begin
        tx_done  = 1'b1;
        ack_wait = 3;
      end else if (ack_wait > 0) begin
        ack_wait--;
`ifdef SPART_ACK_EN
        if (ack_wait == 0) begin
          rx_done = 1'b1;
          rdata   = exp_rsp;
        end
`endif
      end
    end
    chk("rec_finished", fin, 1'b1);
    chk("rec_starts", starts, r.starts);
    chk("rec_done", got_done, r.ok ? onehot : 4'b0000);
    chk("rec_err", got_err, r.ok ? 4'b0000 : onehot);
    if (r.ok) chk("rec_rsp", got_rsp, exp_rsp);
    req = r.req & ~onehot;
    step();
    chk("rec_pulse_cleared", {done, err}, 8'h00);
    chk("rec_busy_after", busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    int late;
    recs[0] = '{4'b1111, 1, 1, 3,   1'b1, 1};
    recs[1] = '{4'b1111, 2, 1, 7,   1'b1, 1};
    recs[2] = '{4'b1111, 3, 1, 1,   1'b1, 1};
    recs[3] = '{4'b1111, 0, 1, 0,   1'b1, 1};
    recs[4] = '{4'b0100, 2, 1, -1,  1'b0, 3};
    recs[5] = '{4'b0101, 0, 1, 4,   1'b1, 1};
    recs[6] = '{4'b1000, 3, 1, 99,  1'b1, 1};
    recs[7] = '{4'b1010, 1, 1, 100, 1'b0, 3};
    recs[8] = '{4'b1010, 3, 2, 10,  1'b1, 2};
    recs[9] = '{4'b0010, 1, 3, 0,   1'b1, 3};

    rst      = 1'b1;
    req      = '0;
    req_data = {exp_frame(3), exp_frame(2), exp_frame(1), exp_frame(0)};
    tx_done  = 1'b0;
    rx_done  = 1'b0;
    rdata    = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_state", {start_transmission, busy, done, err, tdata, rsp_data}, 64'h0);

    // Single requester, tx_done 50 cycles after start.
    req = 4'b0001;
    step();
    chk("t1_busy_next_cycle", busy, 1'b1);
    chk("t1_no_start_cycle1", start_transmission, 1'b0);
    step();
    chk("t1_start_cycle2", start_transmission, 1'b1);
    chk("t1_tdata", tdata, 24'hBEEFDE);
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (start_transmission) extra++;
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
`ifdef SPART_ACK_EN
    chk("t5_no_done_before_rsp", done, 4'b0000);
    repeat (19) step();
    rx_done = 1'b1;
    rdata   = 24'h00A5C3;
    step();
    rx_done = 1'b0;
    chk("t5_done", done, 4'b0001);
    chk("t5_rsp_data", rsp_data, 24'h00A5C3);
`else
    chk("t1_done", done, 4'b0001);
    chk("t1_rsp_zero", rsp_data, 24'h0);
`endif
    chk("t1_err_zero", err, 4'b0000);
    req = 4'b0000;
    step();
    chk("t1_done_one_cycle", done, 4'b0000);
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_single_start", extra, 0);

    for (int n = 0; n < 10; n++) run_rec(recs[n]);

    // Reset ten cycles into SEND, then late tx_done and a stray rx_done in IDLE.
    req = 4'b0001;
    step();
    step();
    chk("t4_start", start_transmission, 1'b1);
    repeat (10) step();
    rst = 1'b1;
    #1;
    chk("t4_outputs_cleared", {start_transmission, busy, done, err, tdata, rsp_data}, 64'h0);
    req = 4'b0000;
    step();
    rst = 1'b0;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    late = 0;
    for (int i = 0; i < 4; i++) begin
      if (done != 0 || err != 0 || busy || start_transmission) late++;
      step();
    end
    chk("t4_late_tx_ignored", late, 0);
    rx_done = 1'b1;
    rdata   = 24'h777777;
    step();
    rx_done = 1'b0;
    step();
    chk("stray_rx_ignored", {busy, done, rsp_data}, 64'h0);

    // Pointer must be back at 0 after reset: 1010 grants requester 1.
    run_rec('{4'b1010, 1, 1, 5, 1'b1, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
